// File: rtl/interrupt_ack_sequencer_pkg.sv
// rtl/interrupt_ack_sequencer_pkg.sv - shared constants and types for the PIC acknowledge path
// Purpose: IRQ count/index width, acknowledge FSM state type, spurious index,
//          and a one-hot helper shared by the sequencer and its resolver.
// Ports:   none (package).
package pic_pkg;

   localparam int NUM_IRQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK1,
      ACK2
   } ack_state_t;

   // Vector index returned when the request vanished before the first INTA.
   localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

   function automatic logic [NUM_IRQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      idx_onehot      = '0;
      idx_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// rtl/interrupt_ack_sequencer_if.sv - CPU-side interrupt bus between sequencer and CPU
// Purpose: groups the CPU handshake (request, acknowledge, vector byte).
// Signals: inta     CPU acknowledge level (CPU drives)
//          int_out  interrupt request to CPU (sequencer drives)
//          data_out vector byte (sequencer drives)
//          data_oe  vector valid / bus drive enable (sequencer drives)
// Modports: master = CPU side, slave = sequencer side.
interface interrupt_ack_sequencer_if;
   import pic_pkg::*;

   logic               inta;
   logic               int_out;
   logic [NUM_IRQ-1:0] data_out;
   logic               data_oe;

   modport master (output inta, input int_out, input data_out, input data_oe);
   modport slave  (input inta, output int_out, output data_out, output data_oe);

endinterface

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// rtl/interrupt_ack_sequencer_priority_resolver.sv - fixed-priority, fully nested winner select
// Purpose: picks the lowest-index eligible request that outranks every in-service level.
// Ports:   eligible  in  unmasked pending requests
//          isr       in  In-Service Register
//          valid     out a serviceable request exists
//          idx       out lowest-index eligible request
//          isr_top   out lowest-index set ISR bit (0 when isr is empty)
module priority_resolver
   import pic_pkg::*;
(
   input  logic [NUM_IRQ-1:0] eligible,
   input  logic [NUM_IRQ-1:0] isr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx,
   output logic [IDX_W-1:0]   isr_top
);

   logic             req_any;
   logic [IDX_W-1:0] req_idx;

   always_comb begin
      req_any = 1'b0;
      req_idx = '0;
      isr_top = '0;
      // Scanning downward leaves the lowest set index in place.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            req_any = 1'b1;
            req_idx = IDX_W'(i);
         end
         if (isr[i]) begin
            isr_top = IDX_W'(i);
         end
      end
      // Only a strictly higher priority level may nest over the in-service one.
      valid = req_any && ((isr == '0) || (req_idx < isr_top));
      idx   = req_idx;
   end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - CPU-facing INTA sequencer with ISR and EOI handling
// Purpose: raises int_out for the winning request, runs the two-pulse INTA
//          handshake, sets ISR / pulses irr_clear on the first pulse, returns
//          {vector_base, idx} on the second, and clears ISR on EOI.
// Ports:   clk, reset          clock, synchronous active-high reset
//          valid_interrupts    pending requests (level)
//          irq_mask            1 = line masked
//          vector_base         vector bits [7:3]
//          eoi / eoi_specific / eoi_level   end-of-interrupt strobe and target
//          irr_clear           one-cycle clear of the acknowledged request
//          isr                 In-Service Register
//          busy                sequencer not idle
//          cpu                 inta / int_out / data_out / data_oe bus
module interrupt_ack_sequencer
   import pic_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_IRQ-1:0]    valid_interrupts,
   input  logic [NUM_IRQ-1:0]    irq_mask,
   input  logic [4:0]            vector_base,
   input  logic                  eoi,
   input  logic                  eoi_specific,
   input  logic [IDX_W-1:0]      eoi_level,
   output logic [NUM_IRQ-1:0]    irr_clear,
   output logic [NUM_IRQ-1:0]    isr,
   output logic                  busy,
   interrupt_ack_sequencer_if.slave cpu
);

   ack_state_t         state_q, state_d;
   logic               inta_q, inta_d;
   logic               int_out_q, int_out_d;
   logic [NUM_IRQ-1:0] data_out_q, data_out_d;
   logic               data_oe_q, data_oe_d;
   logic [NUM_IRQ-1:0] irr_clear_q, irr_clear_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;

   logic               inta_rise, inta_fall;
   logic [NUM_IRQ-1:0] eligible;
   logic               win_valid;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   isr_top;
   logic [NUM_IRQ-1:0] isr_set;
   logic [NUM_IRQ-1:0] eoi_clr;

   assign inta_d    = cpu.inta;
   assign inta_rise = cpu.inta & ~inta_q;
   assign inta_fall = ~cpu.inta & inta_q;
   assign eligible  = valid_interrupts & ~irq_mask;

   priority_resolver u_resolver (
      .eligible (eligible),
      .isr      (isr_q),
      .valid    (win_valid),
      .idx      (win_idx),
      .isr_top  (isr_top)
   );

   always_comb begin
      state_d     = state_q;
      int_out_d   = int_out_q;
      data_out_d  = data_out_q;
      data_oe_d   = data_oe_q;
      irr_clear_d = '0;
      sel_idx_d   = sel_idx_q;
      isr_set     = '0;
      eoi_clr     = '0;

      if (eoi) begin
         if (eoi_specific) begin
            eoi_clr = idx_onehot(eoi_level);
         end else if (isr_q != '0) begin
            eoi_clr = idx_onehot(isr_top);
         end
      end

      case (state_q)
         IDLE: begin
            int_out_d = 1'b0;
            data_oe_d = 1'b0;
            if (win_valid) begin
               state_d   = REQ;
               int_out_d = 1'b1;
            end
         end
         REQ: begin
            if (inta_rise) begin
               state_d   = ACK1;
               int_out_d = 1'b0;
               if (win_valid) begin
                  sel_idx_d   = win_idx;
                  isr_set     = idx_onehot(win_idx);
                  irr_clear_d = idx_onehot(win_idx);
               end else begin
                  // Request withdrawn before acknowledge: answer with the spurious vector.
                  sel_idx_d = SPURIOUS_IDX;
               end
            end else if (!win_valid) begin
               state_d   = IDLE;
               int_out_d = 1'b0;
            end else begin
               int_out_d = 1'b1;
            end
         end
         ACK1: begin
            // A new rise implies the first pulse has already fallen.
            if (inta_rise) begin
               state_d    = ACK2;
               data_out_d = {vector_base, sel_idx_q};
               data_oe_d  = 1'b1;
            end
         end
         ACK2: begin
            if (inta_fall) begin
               state_d   = IDLE;
               data_oe_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // EOI acts on the pre-edge ISR; a same-cycle set on the same bit wins.
      isr_d = (isr_q & ~eoi_clr) | isr_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         inta_q      <= 1'b0;
         int_out_q   <= 1'b0;
         data_out_q  <= '0;
         data_oe_q   <= 1'b0;
         irr_clear_q <= '0;
         isr_q       <= '0;
         sel_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         inta_q      <= inta_d;
         int_out_q   <= int_out_d;
         data_out_q  <= data_out_d;
         data_oe_q   <= data_oe_d;
         irr_clear_q <= irr_clear_d;
         isr_q       <= isr_d;
         sel_idx_q   <= sel_idx_d;
      end
   end

   assign cpu.int_out  = int_out_q;
   assign cpu.data_out = data_out_q;
   assign cpu.data_oe  = data_oe_q;
   assign irr_clear    = irr_clear_q;
   assign isr          = isr_q;
   assign busy         = (state_q != IDLE);

endmodule
